// File: rtl/carpici_pkg.sv
// carpici_pkg: default widths and elaboration-time helpers for the parametrised multiplier.
package carpici_pkg;
    localparam int VERI_BIT_DEF = 32;
    localparam int KIMLIK_BIT_DEF = 4;

    // One 3:2 level turns every full group of three rows into two; leftovers pass through.
    function automatic int csa_rows_next(input int n);
        return 2 * (n / 3) + n % 3;
    endfunction

    function automatic int csa_rows_at(input int w, input int l);
        int n;
        n = w;
        for (int i = 0; i < l; i++) n = csa_rows_next(n);
        return n;
    endfunction

    function automatic int csa_levels(input int w);
        int n;
        int l;
        n = w;
        l = 0;
        while (n > 2) begin
            n = csa_rows_next(n);
            l++;
        end
        return l;
    endfunction

    function automatic logic negate_flag(input logic s0, input logic m0, input logic s1, input logic m1);
        return (s0 & m0) ^ (s1 & m1);
    endfunction
endpackage

// File: rtl/csa_n.sv
// csa_n: N-bit 3:2 carry-save compressor, carry word shifted left and truncated to N bits.
module csa_n
    import carpici_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [N-1:0] c_i,
    output logic [N-1:0] s_o,
    output logic [N-1:0] cy_o
);
    logic [N-2:0] maj;

    assign s_o  = a_i ^ b_i ^ c_i;
    assign maj  = (a_i[N-2:0] & b_i[N-2:0]) | (a_i[N-2:0] & c_i[N-2:0]) | (b_i[N-2:0] & c_i[N-2:0]);
    assign cy_o = {maj, 1'b0};
endmodule

// File: rtl/carpici_pipe_param.sv
// carpici_pipe_param: W x W three-stage multiplier with per-operand signedness,
// global-stall valid/ready handshake, tag passthrough, flush and half select.
module carpici_pipe_param
    import carpici_pkg::*;
#(
    parameter int VERI_BIT   = VERI_BIT_DEF,
    parameter int KIMLIK_BIT = KIMLIK_BIT_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [VERI_BIT-1:0]     islec0_i,
    input  logic                    islec0_isaretli_i,
    input  logic [VERI_BIT-1:0]     islec1_i,
    input  logic                    islec1_isaretli_i,
    input  logic                    yuksek_i,
    input  logic [KIMLIK_BIT-1:0]   kimlik_i,
    input  logic                    islem_gecerli_i,
    output logic                    islem_hazir_o,
    input  logic                    temizle_i,
    output logic [2*VERI_BIT-1:0]   carpim_o,
    output logic [VERI_BIT-1:0]     sonuc_o,
    output logic [KIMLIK_BIT-1:0]   kimlik_o,
    output logic                    carpim_gecerli_o,
    input  logic                    sonuc_hazir_i
);
    localparam int W   = VERI_BIT;
    localparam int P   = 2 * VERI_BIT;
    localparam int LVL = csa_levels(W);

    logic                  ilerle, kabul, s2_load, s3_load;
    logic                  neg0, neg1;
    logic [W-1:0]          mag0, mag1;
    logic [P-1:0]          tree_sum, tree_carry;
    logic [P-1:0]          s1_sum_d, s1_sum_q, s1_carry_d, s1_carry_q;
    logic                  s1_neg_d, s1_neg_q, s1_hi_d, s1_hi_q, s1_v_d, s1_v_q;
    logic [KIMLIK_BIT-1:0] s1_tag_d, s1_tag_q;
    logic [P-1:0]          s2_prod_d, s2_prod_q;
    logic                  s2_neg_d, s2_neg_q, s2_hi_d, s2_hi_q, s2_v_d, s2_v_q;
    logic [KIMLIK_BIT-1:0] s2_tag_d, s2_tag_q;
    logic [P-1:0]          s3_carpim_d, s3_carpim_q;
    logic                  s3_hi_d, s3_hi_q, s3_v_d, s3_v_q;
    logic [KIMLIK_BIT-1:0] s3_tag_d, s3_tag_q;

    assign ilerle  = ~s3_v_q | sonuc_hazir_i;
    assign kabul   = islem_gecerli_i & ilerle & ~temizle_i;
    assign s2_load = ilerle & s1_v_q;
    assign s3_load = ilerle & s2_v_q;

    // Multiply magnitudes; the sign is restored in S3. The most negative value maps to 2^(W-1) unsigned.
    assign neg0 = islec0_isaretli_i & islec0_i[W-1];
    assign neg1 = islec1_isaretli_i & islec1_i[W-1];
    assign mag0 = neg0 ? -islec0_i : islec0_i;
    assign mag1 = neg1 ? -islec1_i : islec1_i;

    for (genvar l = 0; l <= LVL; l++) begin : g_lvl
        localparam int N = csa_rows_at(W, l);
        logic [P-1:0] r [N];
        if (l == 0) begin : g_pp
            for (genvar i = 0; i < W; i++) begin : g_row
                assign r[i] = mag1[i] ? ({{W{1'b0}}, mag0} << i) : '0;
            end
        end else begin : g_red
            localparam int Q = csa_rows_at(W, l - 1);
            for (genvar k = 0; k < Q / 3; k++) begin : g_csa
                csa_n #(.N(P)) u_csa (
                    .a_i (g_lvl[l-1].r[3*k]),
                    .b_i (g_lvl[l-1].r[3*k+1]),
                    .c_i (g_lvl[l-1].r[3*k+2]),
                    .s_o (r[2*k]),
                    .cy_o(r[2*k+1])
                );
            end
            for (genvar k = 0; k < Q % 3; k++) begin : g_pass
                assign r[2*(Q/3)+k] = g_lvl[l-1].r[3*(Q/3)+k];
            end
        end
    end

    assign tree_sum   = g_lvl[LVL].r[0];
    assign tree_carry = g_lvl[LVL].r[1];

    // Data registers load only with a valid beat so bubbles leave the outputs untouched.
    always_comb begin
        s1_v_d      = temizle_i ? 1'b0 : (ilerle ? islem_gecerli_i : s1_v_q);
        s1_sum_d    = kabul ? tree_sum : s1_sum_q;
        s1_carry_d  = kabul ? tree_carry : s1_carry_q;
        s1_neg_d    = kabul ? negate_flag(islec0_isaretli_i, islec0_i[W-1], islec1_isaretli_i, islec1_i[W-1]) : s1_neg_q;
        s1_hi_d     = kabul ? yuksek_i : s1_hi_q;
        s1_tag_d    = kabul ? kimlik_i : s1_tag_q;
        s2_v_d      = temizle_i ? 1'b0 : (ilerle ? s1_v_q : s2_v_q);
        s2_prod_d   = s2_load ? s1_sum_q + s1_carry_q : s2_prod_q;
        s2_neg_d    = s2_load ? s1_neg_q : s2_neg_q;
        s2_hi_d     = s2_load ? s1_hi_q : s2_hi_q;
        s2_tag_d    = s2_load ? s1_tag_q : s2_tag_q;
        s3_v_d      = temizle_i ? 1'b0 : (ilerle ? s2_v_q : s3_v_q);
        s3_carpim_d = s3_load ? (s2_neg_q ? -s2_prod_q : s2_prod_q) : s3_carpim_q;
        s3_hi_d     = s3_load ? s2_hi_q : s3_hi_q;
        s3_tag_d    = s3_load ? s2_tag_q : s3_tag_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_v_q      <= 1'b0;
            s1_sum_q    <= '0;
            s1_carry_q  <= '0;
            s1_neg_q    <= 1'b0;
            s1_hi_q     <= 1'b0;
            s1_tag_q    <= '0;
            s2_v_q      <= 1'b0;
            s2_prod_q   <= '0;
            s2_neg_q    <= 1'b0;
            s2_hi_q     <= 1'b0;
            s2_tag_q    <= '0;
            s3_v_q      <= 1'b0;
            s3_carpim_q <= '0;
            s3_hi_q     <= 1'b0;
            s3_tag_q    <= '0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_sum_q    <= s1_sum_d;
            s1_carry_q  <= s1_carry_d;
            s1_neg_q    <= s1_neg_d;
            s1_hi_q     <= s1_hi_d;
            s1_tag_q    <= s1_tag_d;
            s2_v_q      <= s2_v_d;
            s2_prod_q   <= s2_prod_d;
            s2_neg_q    <= s2_neg_d;
            s2_hi_q     <= s2_hi_d;
            s2_tag_q    <= s2_tag_d;
            s3_v_q      <= s3_v_d;
            s3_carpim_q <= s3_carpim_d;
            s3_hi_q     <= s3_hi_d;
            s3_tag_q    <= s3_tag_d;
        end
    end

    assign islem_hazir_o    = ilerle;
    assign carpim_o         = s3_carpim_q;
    assign sonuc_o          = s3_hi_q ? s3_carpim_q[P-1:W] : s3_carpim_q[W-1:0];
    assign kimlik_o         = s3_tag_q;
    assign carpim_gecerli_o = s3_v_q;
endmodule

// File: tb/tb_carpici_pipe_param.sv
// tb_carpici_pipe_param: directed W=32 scenarios plus a W=8 random back-pressure sweep,
// both checked against a sign-extend-and-multiply reference through a scoreboard.
module tb_carpici_pipe_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [63:0] c;
        logic [31:0] s;
        logic [3:0]  t;
    } exp_t;
    exp_t q32[$];
    exp_t q8[$];
    exp_t e32, e8;

    logic [31:0] a32 = '0, b32 = '0;
    logic        as32 = 0, bs32 = 0, hi32 = 0, v32 = 0, fl32 = 0, rdy32 = 1;
    logic [3:0]  t32 = '0;
    logic        hz32, vo32;
    logic [63:0] c32;
    logic [31:0] s32;
    logic [3:0]  k32;

    logic [7:0]  a8 = '0, b8 = '0;
    logic        as8 = 0, bs8 = 0, hi8 = 0, v8 = 0, rdy8 = 1;
    logic [3:0]  t8 = '0;
    logic        hz8, vo8;
    logic [15:0] c8;
    logic [7:0]  s8;
    logic [3:0]  k8;

    carpici_pipe_param #(.VERI_BIT(32), .KIMLIK_BIT(4)) u32 (
        .clk_i(clk), .rst_i(rst),
        .islec0_i(a32), .islec0_isaretli_i(as32), .islec1_i(b32), .islec1_isaretli_i(bs32),
        .yuksek_i(hi32), .kimlik_i(t32), .islem_gecerli_i(v32), .islem_hazir_o(hz32),
        .temizle_i(fl32), .carpim_o(c32), .sonuc_o(s32), .kimlik_o(k32),
        .carpim_gecerli_o(vo32), .sonuc_hazir_i(rdy32)
    );

    carpici_pipe_param #(.VERI_BIT(8), .KIMLIK_BIT(4)) u8 (
        .clk_i(clk), .rst_i(rst),
        .islec0_i(a8), .islec0_isaretli_i(as8), .islec1_i(b8), .islec1_isaretli_i(bs8),
        .yuksek_i(hi8), .kimlik_i(t8), .islem_gecerli_i(v8), .islem_hazir_o(hz8),
        .temizle_i(1'b0), .carpim_o(c8), .sonuc_o(s8), .kimlik_o(k8),
        .carpim_gecerli_o(vo8), .sonuc_hazir_i(rdy8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: sign- or zero-extend both operands to 64 bits and multiply.
    function automatic exp_t mk(input int w, input logic [31:0] a, input logic as, input logic [31:0] b,
                                input logic bs, input logic hi, input logic [3:0] t);
        logic [63:0] ae, be, p, m;
        exp_t r;
        ae = {32'b0, a};
        be = {32'b0, b};
        if (as && a[w-1]) ae = ae | (~64'd0 << w);
        if (bs && b[w-1]) be = be | (~64'd0 << w);
        m = (w == 32) ? ~64'd0 : (64'd1 << (2 * w)) - 64'd1;
        p = (ae * be) & m;
        r.c = p;
        r.s = 32'(hi ? (p >> w) : (p & ((64'd1 << w) - 64'd1)));
        r.t = t;
        return r;
    endfunction

    task automatic drv32(input logic [31:0] a, input logic as, input logic [31:0] b, input logic bs,
                         input logic hi, input logic [3:0] t);
        int n;
        logic acc;
        n = 0;
        a32 = a; as32 = as; b32 = b; bs32 = bs; hi32 = hi; t32 = t; v32 = 1'b1;
        do begin
            @(negedge clk);
            acc = hz32 && !fl32;
            if (acc) q32.push_back(mk(32, a, as, b, bs, hi, t));
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("accept_timeout32", 64'(acc), 64'd1);
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vo32 && n < 20);
    endtask

    always @(negedge clk) begin
        if (rst) q32.delete();
        else begin
            if (vo32 && rdy32) begin
                if (q32.size() == 0) chk("spurious32", 64'd1, 64'd0);
                else begin
                    e32 = q32.pop_front();
                    chk("carpim32", c32, e32.c);
                    chk("sonuc32", 64'(s32), 64'(e32.s));
                    chk("kimlik32", 64'(k32), 64'(e32.t));
                end
            end
            if (fl32) q32.delete();
        end
    end

    always @(negedge clk) begin
        if (rst) q8.delete();
        else if (vo8 && rdy8) begin
            if (q8.size() == 0) chk("spurious8", 64'd1, 64'd0);
            else begin
                e8 = q8.pop_front();
                chk("carpim8", 64'(c8), 64'(e8.c[15:0]));
                chk("sonuc8", 64'(s8), 64'(e8.s[7:0]));
                chk("kimlik8", 64'(k8), 64'(e8.t));
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c0, sent, lim;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(vo32), 64'd0);
        chk("rst_ready", 64'(hz32), 64'd1);
        chk("rst_carpim", c32, 64'd0);
        chk("rst_sonuc", 64'(s32), 64'd0);
        chk("rst_kimlik", 64'(k32), 64'd0);
        chk("rst_valid8", 64'(vo8), 64'd0);
        @(posedge clk); #1;

        drv32(32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 4'd5); v32 = 1'b0;
        wait_out(n);
        chk("lat_uu", 64'(n), 64'd3);
        chk("lit_uu_c", c32, 64'hFFFFFFFE00000001);
        chk("lit_uu_s", 64'(s32), 64'h1);
        chk("lit_uu_k", 64'(k32), 64'd5);
        @(posedge clk); #1;
        drv32(32'h80000000, 1'b1, 32'h80000000, 1'b1, 1'b1, 4'd6); v32 = 1'b0;
        wait_out(n);
        chk("lit_ss_c", c32, 64'h4000000000000000);
        chk("lit_ss_s", 64'(s32), 64'h40000000);
        @(posedge clk); #1;
        drv32(32'hFFFFFFFD, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 4'd7); v32 = 1'b0;
        wait_out(n);
        chk("lit_su_c", c32, 64'hFFFFFFFD00000003);
        @(posedge clk); #1;

        c0 = cyc;
        drv32(32'hFFFFFFFF, 1'b0, 32'hFFFFFFFD, 1'b1, 1'b1, 4'd8);
        drv32(32'h0, 1'b1, 32'h80000000, 1'b1, 1'b1, 4'd9);
        for (int i = 0; i < 18; i++)
            drv32($urandom, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), 4'($urandom));
        v32 = 1'b0;
        chk("throughput", 64'(cyc - c0), 64'd20);
        repeat (6) @(posedge clk); #1;

        fork
            begin
                for (int i = 0; i < 6; i++)
                    drv32($urandom, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), 4'(i + 10));
                v32 = 1'b0;
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!vo32 && n < 20);
                chk("stall_first", 64'(vo32), 64'd1);
                @(posedge clk); #1 rdy32 = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("stall_valid", 64'(vo32), 64'd1);
                    chk("stall_ready", 64'(hz32), 64'd0);
                    chk("stall_c", c32, (q32.size() > 0) ? q32[0].c : 64'hX);
                    chk("stall_s", 64'(s32), (q32.size() > 0) ? 64'(q32[0].s) : 64'hX);
                    chk("stall_k", 64'(k32), (q32.size() > 0) ? 64'(q32[0].t) : 64'hX);
                end
                @(posedge clk); #1 rdy32 = 1'b1;
            end
        join
        lim = 0;
        while (q32.size() != 0 && lim < 50) begin @(negedge clk); lim++; end
        chk("stall_drain", 64'(q32.size()), 64'd0);
        @(posedge clk); #1;

        rdy32 = 1'b0;
        for (int i = 0; i < 3; i++)
            drv32($urandom, 1'(i), $urandom, 1'b1, 1'b0, 4'(i + 1));
        a32 = 32'd9; b32 = 32'd9; t32 = 4'hF; v32 = 1'b1; fl32 = 1'b1;
        @(negedge clk);
        chk("flush_full", 64'(vo32), 64'd1);
        chk("flush_ready", 64'(hz32), 64'd0);
        @(posedge clk); #1 fl32 = 1'b0; v32 = 1'b0; rdy32 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("flush_valid", 64'(vo32), 64'd0);
        end
        @(posedge clk); #1;
        drv32(32'd1234, 1'b0, 32'd5678, 1'b0, 1'b0, 4'hA); v32 = 1'b0;
        wait_out(n);
        chk("flush_lat", 64'(n), 64'd3);
        @(posedge clk); #1;

        drv32(32'hDEADBEEF, 1'b1, 32'h12345678, 1'b0, 1'b1, 4'h3);
        drv32(32'hCAFEF00D, 1'b0, 32'h0BADF00D, 1'b1, 1'b0, 4'h4);
        v32 = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("midrst_valid", 64'(vo32), 64'd0);
            chk("midrst_c", c32, 64'd0);
            chk("midrst_s", 64'(s32), 64'd0);
            chk("midrst_k", 64'(k32), 64'd0);
        end
        chk("midrst_ready", 64'(hz32), 64'd1);
        @(posedge clk); #1;

        sent = 0;
        lim = 0;
        while (sent < 10000 && lim < 60000) begin
            a8 = 8'($urandom); b8 = 8'($urandom);
            as8 = 1'($urandom); bs8 = 1'($urandom); hi8 = 1'($urandom); t8 = 4'($urandom);
            v8 = ($urandom_range(0, 3) != 0);
            rdy8 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (v8 && hz8) begin
                q8.push_back(mk(8, {24'b0, a8}, as8, {24'b0, b8}, bs8, hi8, t8));
                sent++;
            end
            @(posedge clk); #1;
            lim++;
        end
        v8 = 1'b0;
        rdy8 = 1'b1;
        chk("sweep_sent", 64'(sent), 64'd10000);
        lim = 0;
        while ((q8.size() != 0 || q32.size() != 0) && lim < 50) begin @(negedge clk); lim++; end
        chk("drain8", 64'(q8.size()), 64'd0);
        chk("drain32", 64'(q32.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
